// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receive engine with mid-bit sampling, stop-bit check,
// framing-error / overrun pulses and a single-byte valid/ready holding register.
// Optional even parity (8E1) is enabled by defining UART_RX_PARITY_EN.
module uart_rx_core #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       parity_err_o,
    output logic       overrun_o
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreak
    } state_e;

    state_e          state_q, state_d;
    logic            rx_meta, rx_s;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      bit_q;
    logic [7:0]      shift_q;

    // Control strobes from the output decoder
    logic            cnt_clr;
    logic            data_tick;
    logic            good_frame;
    logic            frame_err;

`ifdef UART_RX_PARITY_EN
    logic            par_tick;
    logic            par_bad_q;
    logic            parity_err;
`endif

    logic            cnt_last;
    assign cnt_last = (cnt_q == CntLast);

    // Two-flop synchroniser; resets to the idle line level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_s    <= rx_meta;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (!rx_s) state_d = StStart;
            end
            StStart: begin
                // A high line at mid start bit is a glitch, not a frame
                if (cnt_q == CntHalf) state_d = rx_s ? StIdle : StData;
            end
            StData: begin
                if (cnt_last && (bit_q == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
                    state_d = StParity;
`else
                    state_d = StStop;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (cnt_last) state_d = StStop;
            end
`endif
            StStop: begin
                // Leave at mid stop bit so a back-to-back start edge is not missed
                if (cnt_last) state_d = rx_s ? StIdle : StBreak;
            end
            StBreak: begin
                if (rx_s) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM output decode: counter control and per-frame result strobes
    always_comb begin
        cnt_clr    = 1'b0;
        data_tick  = 1'b0;
        good_frame = 1'b0;
        frame_err  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_tick   = 1'b0;
        parity_err = 1'b0;
`endif
        case (state_q)
            StIdle:  cnt_clr = 1'b1;
            StStart: cnt_clr = (cnt_q == CntHalf);
            StData:  data_tick = cnt_last;
`ifdef UART_RX_PARITY_EN
            StParity: par_tick = cnt_last;
`endif
            StStop: begin
                if (cnt_last) begin
                    if (!rx_s) begin
                        // Framing error takes precedence over parity error
                        frame_err = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if (par_bad_q) begin
                        parity_err = 1'b1;
`endif
                    end else begin
                        good_frame = 1'b1;
                    end
                end
            end
            StBreak: cnt_clr = 1'b1;
            default: cnt_clr = 1'b1;
        endcase
    end

    // Cycle counter, bit counter and data shift register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
        end else begin
            if (cnt_clr || cnt_last) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (state_q == StIdle) begin
                bit_q <= 3'd0;
            end else if (data_tick) begin
                bit_q <= bit_q + 3'd1;
            end
            // LSB arrives first, so shift right and insert at the top
            if (data_tick) begin
                shift_q <= {rx_s, shift_q[7:1]};
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even parity: the parity bit must equal the XOR of the data bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_bad_q <= 1'b0;
        end else if (par_tick) begin
            par_bad_q <= rx_s ^ (^shift_q);
        end
    end

    // Registered parity-error pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_err_o <= 1'b0;
        end else begin
            parity_err_o <= parity_err;
        end
    end
`else
    assign parity_err_o = 1'b0;
`endif

    // Holding register, handshake and registered error pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_o      <= 8'h00;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            frame_err_o <= frame_err;
            overrun_o   <= 1'b0;
            if (good_frame) begin
                // Accept-and-arrive in the same cycle reloads without overrun
                if (!valid_o || ready_i) begin
                    data_o  <= shift_q;
                    valid_o <= 1'b1;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: randomized and directed frames against a frame-level model;
// expected events go into a scoreboard queue checked by an independent monitor.
`timescale 1ns/1ps
module tb_uart_rx_core;

    localparam int unsigned C = 8;
`ifdef UART_RX_PARITY_EN
    localparam longint Lat = C / 2 + 10 * C + 3;
`else
    localparam longint Lat = C / 2 + 9 * C + 3;
`endif

    typedef enum int {EvByte, EvFerr, EvPerr, EvOvr} ev_e;
    typedef struct {
        ev_e        kind;
        logic [7:0] data;
        longint     at;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;
    logic       frame_err_o;
    logic       parity_err_o;
    logic       overrun_o;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         evcount = 0;
    longint     cyc = 0;
    logic       model_full = 1'b0;
    logic [7:0] model_data = 8'h00;
    logic       prev_valid = 1'b0;
    logic       prev_acc = 1'b0;

    uart_rx_core #(.CLKS_PER_BIT(C)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_i        (rx_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .frame_err_o (frame_err_o),
        .parity_err_o(parity_err_o),
        .overrun_o   (overrun_o)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic ev(input ev_e k);
        exp_t e;
        evcount++;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d, required none", k, cyc);
        end else begin
            e = sb.pop_front();
            chk("event_kind", 64'(k), 64'(e.kind));
            chk("event_cycle", 64'(cyc), 64'(e.at));
            if (k == EvByte || k == EvOvr) chk("data_o", 64'(data_o), 64'(e.data));
        end
    endtask

    // Monitor: every output event pops one expectation
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            prev_acc   = 1'b0;
        end else begin
            if (frame_err_o) ev(EvFerr);
            if (parity_err_o) ev(EvPerr);
            if (overrun_o) ev(EvOvr);
            if (valid_o && (!prev_valid || prev_acc)) ev(EvByte);
            prev_valid = valid_o;
            prev_acc   = valid_o && ready_i;
        end
    end

    task automatic hold(input logic v, input int n);
        rx_i = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one frame and predict its outcome from the frame contents alone
    task automatic send(input logic [7:0] d, input logic stop_b, input logic par_b,
                        input logic rdy);
        exp_t   e;
        logic   perr;
        ready_i = rdy;
        if (rdy) model_full = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr = (par_b != ^d);
`else
        perr = 1'b0;
`endif
        e.at   = cyc + Lat;
        e.data = model_data;
        if (!stop_b) begin
            e.kind = EvFerr;
        end else if (perr) begin
            e.kind = EvPerr;
        end else if (model_full) begin
            e.kind = EvOvr;
        end else begin
            e.kind     = EvByte;
            e.data     = d;
            model_data = d;
            model_full = !rdy;
        end
        sb.push_back(e);
        hold(1'b0, C);
        for (int i = 0; i < 8; i++) hold(d[i], C);
`ifdef UART_RX_PARITY_EN
        hold(par_b, C);
`endif
        hold(stop_b, C);
    endtask

    function automatic logic good_par(input logic [7:0] d);
        return ^d;
    endfunction

    initial begin
        int n0;
        logic [7:0] d;
        rst     = 1'b1;
        rx_i    = 1'b1;
        ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_data", 64'(data_o), 64'h00);
        chk("reset_valid", 64'(valid_o), 64'h0);
        chk("reset_ferr", 64'(frame_err_o), 64'h0);
        chk("reset_perr", 64'(parity_err_o), 64'h0);
        chk("reset_ovr", 64'(overrun_o), 64'h0);
        rst = 1'b0;
        hold(1'b1, 5);

        // Single byte, latency and one-cycle valid
        send(8'hA5, 1'b1, good_par(8'hA5), 1'b1);
        chk("valid_one_cycle", 64'(valid_o), 64'h0);
        hold(1'b1, 5);

        // Start glitch produces nothing
        n0 = evcount;
        hold(1'b0, 2);
        hold(1'b1, 100);
        chk("glitch_no_event", 64'(evcount), 64'(n0));

        // Framing error, held-low line, then recovery
        send(8'h3C, 1'b0, good_par(8'h3C), 1'b1);
        hold(1'b0, 30);
        hold(1'b1, C);
        send(8'h5A, 1'b1, good_par(8'h5A), 1'b1);
        hold(1'b1, 5);

        // Back-to-back frames into a full holding register
        send(8'h11, 1'b1, good_par(8'h11), 1'b0);
        send(8'h22, 1'b1, good_par(8'h22), 1'b0);
        chk("overrun_keeps_data", 64'(data_o), 64'h11);
        chk("overrun_keeps_valid", 64'(valid_o), 64'h1);
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        ready_i    = 1'b0;
        model_full = 1'b0;
        chk("valid_cleared_after_accept", 64'(valid_o), 64'h0);
        hold(1'b1, 5);

        // Reset in the middle of a frame
        send(8'h33, 1'b1, good_par(8'h33), 1'b0);
        hold(1'b1, 5);
        hold(1'b0, C);
        hold(1'b1, 3 * C + C / 2);
        rst = 1'b1;
        #1;
        chk("midreset_valid", 64'(valid_o), 64'h0);
        chk("midreset_data", 64'(data_o), 64'h00);
        chk("midreset_errs", 64'({frame_err_o, parity_err_o, overrun_o}), 64'h0);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        model_full = 1'b0;
        model_data = 8'h00;
        hold(1'b1, 2 * C);
        send(8'h81, 1'b1, good_par(8'h81), 1'b1);
        hold(1'b1, 5);

`ifdef UART_RX_PARITY_EN
        send(8'h07, 1'b1, 1'b0, 1'b1);
        hold(1'b1, 5);
        send(8'h07, 1'b1, 1'b1, 1'b1);
        hold(1'b1, 5);
`endif

        // Randomized frames: data, stop/parity faults and consumer readiness
        for (int i = 0; i < 30; i++) begin
            d = 8'($urandom);
            send(d, ($urandom_range(0, 7) != 0),
                 good_par(d) ^ ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 2) != 0));
            hold(1'b1, $urandom_range(3, 15));
        end

        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
